// File: rtl/spi_packet_assembler.sv
// Receive-side chunk reassembler: shifts nbits_in-bit chunks, first chunk in the MSBs,
// into one nbits_out-bit packet and presents it on a val/rdy output port.
module spi_packet_assembler #(
    parameter int unsigned nbits_in  = 8,
    parameter int unsigned nbits_out = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [nbits_in-1:0]  req_msg,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [nbits_out-1:0] resp_msg
);

    localparam int unsigned NUM_REGS = (nbits_out + nbits_in - 1) / nbits_in;
    localparam int unsigned CNT_BITS = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(NUM_REGS - 1);

    logic [nbits_out-1:0] asm_q, asm_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                 full_q, full_d;
    logic                 req_fire;
    logic                 resp_fire;

    assign resp_val  = full_q;
    assign resp_msg  = asm_q;
    assign req_rdy   = ~full_q | resp_rdy;
    assign req_fire  = req_val & req_rdy;
    assign resp_fire = full_q & resp_rdy;

    // A completing chunk re-asserts full even when the current packet leaves this cycle.
    always_comb begin
        asm_d  = asm_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (resp_fire) begin
            full_d = 1'b0;
        end
        if (req_fire) begin
            asm_d = nbits_out'({asm_q, req_msg});
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_q  <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

endmodule

// File: tb/tb_spi_packet_assembler.sv
// Directed bench for spi_packet_assembler: 8->16, 8->12 and 8->8 instances driven from
// per-cycle vector tables, plus a hand-written mid-stream reset sequence.
module tb_spi_packet_assembler;

    typedef struct {
        bit          rv;
        logic [7:0]  msg;
        bit          rr;
        bit          e_rdy;
        bit          e_val;
        logic [15:0] e_msg;
    } vec_t;

    logic clk;
    logic rst_n;

    logic        rv16, rr16, rdy16, val16;
    logic [7:0]  m16;
    logic [15:0] o16;
    logic        rv12, rr12, rdy12, val12;
    logic [7:0]  m12;
    logic [11:0] o12;
    logic        rv8, rr8, rdy8, val8;
    logic [7:0]  m8;
    logic [7:0]  o8;

    int n_cmp;
    int n_bad;
    vec_t tab[$];

    spi_packet_assembler #(.nbits_in(8), .nbits_out(16)) u_d16 (
        .clk(clk), .reset(rst_n), .req_val(rv16), .req_rdy(rdy16), .req_msg(m16),
        .resp_val(val16), .resp_rdy(rr16), .resp_msg(o16));
    spi_packet_assembler #(.nbits_in(8), .nbits_out(12)) u_d12 (
        .clk(clk), .reset(rst_n), .req_val(rv12), .req_rdy(rdy12), .req_msg(m12),
        .resp_val(val12), .resp_rdy(rr12), .resp_msg(o12));
    spi_packet_assembler #(.nbits_in(8), .nbits_out(8)) u_d8 (
        .clk(clk), .reset(rst_n), .req_val(rv8), .req_rdy(rdy8), .req_msg(m8),
        .resp_val(val8), .resp_rdy(rr8), .resp_msg(o8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rv, logic [7:0] msg, bit rr, bit e_rdy, bit e_val,
                                logic [15:0] e_msg);
        vec_t v;
        v.rv = rv; v.msg = msg; v.rr = rr;
        v.e_rdy = e_rdy; v.e_val = e_val; v.e_msg = e_msg;
        return v;
    endfunction

    // Each row: inputs driven after the falling edge, outputs checked before the rising edge.
    task automatic apply_table(input int sel, input string tag);
        logic        a_rdy, a_val;
        logic [15:0] a_msg;
        for (int i = 0; i < tab.size(); i++) begin
            @(negedge clk);
            case (sel)
                16:      begin rv16 = tab[i].rv; m16 = tab[i].msg; rr16 = tab[i].rr; end
                12:      begin rv12 = tab[i].rv; m12 = tab[i].msg; rr12 = tab[i].rr; end
                default: begin rv8  = tab[i].rv; m8  = tab[i].msg; rr8  = tab[i].rr; end
            endcase
            #1;
            case (sel)
                16:      begin a_rdy = rdy16; a_val = val16; a_msg = o16; end
                12:      begin a_rdy = rdy12; a_val = val12; a_msg = 16'(o12); end
                default: begin a_rdy = rdy8;  a_val = val8;  a_msg = 16'(o8); end
            endcase
            chk($sformatf("%s[%0d].req_rdy", tag, i), 16'(a_rdy), 16'(tab[i].e_rdy));
            chk($sformatf("%s[%0d].resp_val", tag, i), 16'(a_val), 16'(tab[i].e_val));
            chk($sformatf("%s[%0d].resp_msg", tag, i), a_msg, tab[i].e_msg);
        end
        @(negedge clk);
        rv16 = 1'b0; rv12 = 1'b0; rv8 = 1'b0;
        tab.delete();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0;
        rv16 = 0; m16 = '0; rr16 = 0;
        rv12 = 0; m12 = '0; rr12 = 0;
        rv8  = 0; m8  = '0; rr8  = 0;
        repeat (2) @(negedge clk);
        chk("reset.val16", 16'(val16), 16'h0);
        chk("reset.msg16", o16, 16'h0);
        chk("reset.val12", 16'(val12), 16'h0);
        chk("reset.val8",  16'(val8),  16'h0);
        rst_n = 1'b1;
        #1;
        chk("post_reset.rdy16", 16'(rdy16), 16'h1);

        // 8->16: basic pair, backpressure, then back-to-back streaming
        tab.push_back(mk(1, 8'hAB, 1, 1, 0, 16'h0000));
        tab.push_back(mk(1, 8'hCD, 1, 1, 0, 16'h00AB));
        tab.push_back(mk(0, 8'h00, 1, 1, 1, 16'hABCD));
        tab.push_back(mk(0, 8'h00, 1, 1, 0, 16'hABCD));
        tab.push_back(mk(1, 8'h12, 0, 1, 0, 16'hABCD));
        tab.push_back(mk(1, 8'h34, 0, 1, 0, 16'hCD12));
        tab.push_back(mk(1, 8'h56, 0, 0, 1, 16'h1234));
        tab.push_back(mk(1, 8'h56, 0, 0, 1, 16'h1234));
        tab.push_back(mk(1, 8'h56, 1, 1, 1, 16'h1234));
        tab.push_back(mk(1, 8'h78, 1, 1, 0, 16'h3456));
        tab.push_back(mk(0, 8'h00, 1, 1, 1, 16'h5678));
        tab.push_back(mk(0, 8'h00, 1, 1, 0, 16'h5678));
        tab.push_back(mk(1, 8'h01, 1, 1, 0, 16'h5678));
        tab.push_back(mk(1, 8'h02, 1, 1, 0, 16'h7801));
        tab.push_back(mk(1, 8'h03, 1, 1, 1, 16'h0102));
        tab.push_back(mk(1, 8'h04, 1, 1, 0, 16'h0203));
        tab.push_back(mk(0, 8'h00, 1, 1, 1, 16'h0304));
        tab.push_back(mk(0, 8'h00, 1, 1, 0, 16'h0304));
        apply_table(16, "d16");

        // 8->12: top nibble of the first chunk is dropped
        tab.push_back(mk(1, 8'h5A, 1, 1, 0, 16'h0000));
        tab.push_back(mk(1, 8'hBC, 1, 1, 0, 16'h005A));
        tab.push_back(mk(0, 8'h00, 1, 1, 1, 16'h0ABC));
        tab.push_back(mk(0, 8'h00, 1, 1, 0, 16'h0ABC));
        apply_table(12, "d12");

        // 8->8: one-entry pipeline register with toggling consumer ready
        tab.push_back(mk(1, 8'hA0, 1, 1, 0, 16'h0000));
        tab.push_back(mk(1, 8'hA1, 0, 0, 1, 16'h00A0));
        tab.push_back(mk(1, 8'hA1, 1, 1, 1, 16'h00A0));
        tab.push_back(mk(1, 8'hA2, 1, 1, 1, 16'h00A1));
        tab.push_back(mk(1, 8'hA3, 0, 0, 1, 16'h00A2));
        tab.push_back(mk(1, 8'hA3, 1, 1, 1, 16'h00A2));
        tab.push_back(mk(0, 8'h00, 1, 1, 1, 16'h00A3));
        tab.push_back(mk(0, 8'h00, 1, 1, 0, 16'h00A3));
        apply_table(8, "d8");

        // Mid-stream reset discards the partial packet
        rv16 = 1'b1; m16 = 8'h11; rr16 = 1'b1;
        @(negedge clk);
        rv16 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.val", 16'(val16), 16'h0);
        chk("rst_mid.msg", o16, 16'h0);
        @(negedge clk);
        chk("rst_low.val", 16'(val16), 16'h0);
        rst_n = 1'b1;
        rv16 = 1'b1; m16 = 8'h22;
        #1;
        chk("rst_after.rdy", 16'(rdy16), 16'h1);
        chk("rst_after.val", 16'(val16), 16'h0);
        @(negedge clk);
        m16 = 8'h33;
        #1;
        chk("rst_first.val", 16'(val16), 16'h0);
        chk("rst_first.msg", o16, 16'h0022);
        @(negedge clk);
        rv16 = 1'b0;
        #1;
        chk("rst_pkt.val", 16'(val16), 16'h1);
        chk("rst_pkt.msg", o16, 16'h2233);
        @(negedge clk);
        #1;
        chk("rst_pkt_gone.val", 16'(val16), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_packet_assembler.md
Name: spi_packet_assembler

Overview:
- Reassembles a stream of small nbits_in-bit chunks, received MSB-chunk first, into one nbits_out-bit packet.
- It is the receive-side counterpart to the packet disassembler. It sits between the SPI minion/master shift logic and the wide message consumer.
- Chunk ordering matches the disassembler, so disassembler-to-assembler with equal widths is lossless.
- Uses val/rdy on both sides and supports full-throughput back-to-back packets.

Parameters:
- nbits_in, 8, width of each incoming chunk; must satisfy 1 <= nbits_in <= nbits_out.
- nbits_out, 8, width of the assembled output packet.
- num_regs, derived (do not set): ceil(nbits_out/nbits_in), the number of chunks per packet.
- cnt_bits, derived (do not set): max(1, $clog2(num_regs)), the chunk counter width.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low (0 = reset); one clock; reset is asynchronous and active-low.
- req_val  input  1  an incoming chunk is valid.
- req_rdy  output  1  the block can accept a chunk this cycle.
- req_msg  input  nbits_in  chunk data.
- resp_val  output  1  an assembled packet is available.
- resp_rdy  input  1  the consumer accepts the packet this cycle.
- resp_msg  output  nbits_out  assembled packet.

Behaviour:
- State:
  - shift register asm[nbits_out-1:0]
  - chunk counter cnt (0..num_regs-1)
  - full flag
- Reset: while reset is low, asynchronously force asm=0, cnt=0, full=0. Therefore resp_val=0 and resp_msg=0; req_rdy is 1 as soon as reset is high.
- Combinational outputs:
  - resp_val = full
  - resp_msg = asm
  - req_rdy = ~full | resp_rdy
- req_fire = req_val & req_rdy; resp_fire = resp_val & resp_rdy.
- On req_fire:
  - asm <= {asm shifted left by nbits_in, req_msg}, truncated to nbits_out.
  - The first chunk therefore lands in the MSBs.
  - When nbits_out % nbits_in != 0, the top (num_regs*nbits_in - nbits_out) bits of the FIRST chunk are discarded; only its low bits survive.
- Counter:
  - On req_fire with cnt == num_regs-1: cnt <= 0, full <= 1.
  - Otherwise on req_fire: cnt <= cnt+1.
- Full flag:
  - resp_fire without completing req_fire: full <= 0.
  - resp_fire together with a completing req_fire: full stays 1 and the new packet is presented.
- Accumulating state: cnt != 0, or cnt == 0 with full == 0 mid-stream.
  - The block accepts chunks whenever req_val is high.
  - The block never drops or reorders chunks.
- Latency: resp_val rises the cycle after the last chunk of a packet is accepted.
- Backpressure: while full=1 and resp_rdy=0:
  - req_rdy=0.
  - asm and cnt are frozen.
  - resp_msg is held stable.
- Simultaneous events, full=1 and resp_rdy=1:
  - The first chunk of the next packet is accepted in the same cycle the current packet leaves. Sustained throughput is one packet per num_regs cycles.
  - Stale bits in asm need no clear: all of asm is overwritten after num_regs shifts.
- num_regs == 1 (nbits_in == nbits_out): the block degenerates to a one-entry val/rdy pipeline register with full throughput.
- Reset mid-operation: any partial packet and any unsent full packet are discarded. The first chunk accepted after reset is treated as the MSB chunk.
- X-safety: no state changes when req_val=0 and resp_fire=0.

Test Plan:
- in=8, out=16, resp_rdy=1; send 0xAB then 0xCD on consecutive cycles -> resp_val=1 exactly one cycle after the 0xCD fire, resp_msg=0xABCD, one-cycle pulse.
- in=8, out=12; send 0x5A, 0xBC -> resp_msg=0xABC; the top nibble 0x5 is dropped.
- in=8, out=16, resp_rdy=0; send 0x12, 0x34, then offer 0x56 -> resp_val=1, resp_msg=0x1234 held, req_rdy=0, 0x56 not accepted. Raise resp_rdy -> 0x56 accepted that cycle; next packet 0x56xx assembles correctly.
- in=8, out=16, resp_rdy=1, req_val held high; stream 0x01,0x02,0x03,0x04 -> req_rdy never drops; packets 0x0102 then 0x0304 emitted two cycles apart.
- in=8, out=16; accept 0x11, pull reset low for one cycle mid-cycle, then send 0x22,0x33 -> resp_val=0 during and after reset until 0x33 is accepted; resp_msg=0x3322 is not produced, 0x2233 is.
- in=out=8; stream 0xA0..0xA3 with resp_rdy toggling 1,0,1,1 -> every value appears exactly once, in order, each held while resp_rdy=0.
